// File: rtl/range_meas_pkg.sv
// Shared types and cycle-count helpers for the ultrasonic range front end.
package range_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } meas_state_t;

  // Widened to 64 bits because clk_hz * us overflows 32 bits at 50 MHz.
  function automatic int unsigned us_to_cyc(input longint unsigned clk_hz,
                                            input longint unsigned us);
    return 32'(clk_hz * us / 64'd1_000_000);
  endfunction

  function automatic int unsigned ms_to_cyc(input longint unsigned clk_hz,
                                            input longint unsigned ms);
    return 32'(clk_hz * ms / 64'd1_000);
  endfunction

  function automatic int cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-ones range word, reported when no echo was measured.
  function automatic int unsigned range_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous echo line, with rise/fall strobes.
module echo_sync
  import range_meas_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= echo;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;
  assign fall = ~sync & sync_d;

endmodule

// File: rtl/ultrasonic_range_meas.sv
// HC-SR04 style driver: triggers the sensor, times the echo and publishes range in cm.
module ultrasonic_range_meas
  import range_meas_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned PERIOD_MS  = 60,
  parameter int unsigned TIMEOUT_US = 38000,
  parameter int unsigned US_PER_CM  = 58,
  parameter int unsigned RANGE_W    = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_echo,
  output logic               o_trig,
  output logic [RANGE_W-1:0] o_range,
  output logic               o_valid,
  output logic               o_timeout,
  output logic               o_busy
);

  localparam int unsigned TRIG_CYC    = us_to_cyc(64'(CLK_HZ), 64'(TRIG_US));
  localparam int unsigned PERIOD_CYC  = ms_to_cyc(64'(CLK_HZ), 64'(PERIOD_MS));
  localparam int unsigned TIMEOUT_CYC = us_to_cyc(64'(CLK_HZ), 64'(TIMEOUT_US));
  localparam int unsigned CM_CYC      = us_to_cyc(64'(CLK_HZ), 64'(US_PER_CM));

  localparam int PERIOD_W = cnt_w(PERIOD_CYC);
  localparam int TO_W     = cnt_w(TIMEOUT_CYC);
  localparam int PRE_W    = cnt_w(CM_CYC);

  localparam logic [PERIOD_W-1:0] TRIG_LAST   = PERIOD_W'(TRIG_CYC - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST    = PRE_W'(CM_CYC - 1);
  localparam logic [RANGE_W-1:0]  RANGE_TOP   = RANGE_W'(range_max(RANGE_W));

  meas_state_t state;
  meas_state_t state_next;

  logic [PERIOD_W-1:0] period_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic [RANGE_W-1:0]  cm_cnt;
  logic [RANGE_W-1:0]  cm_next;
  logic                pre_wrap;
  logic                to_expired;
  logic                finish_ok;
  logic                finish_timeout;
  logic                echo_rise;
  logic                echo_fall;

  echo_sync u_echo_sync (
    .clk  (i_clk),
    .rst  (i_rst),
    .echo (i_echo),
    .rise (echo_rise),
    .fall (echo_fall)
  );

  // cm_next includes this cycle's wrap so an echo of exactly k*CM_CYC reads as k cm.
  assign pre_wrap   = (pre_cnt == PRE_LAST);
  assign to_expired = (to_cnt >= TO_LAST);
  assign cm_next    = (pre_wrap && cm_cnt != RANGE_TOP) ? cm_cnt + 1'b1 : cm_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    finish_ok      = 1'b0;
    finish_timeout = 1'b0;
    unique case (state)
      IDLE:      if (i_en) state_next = TRIG;
      TRIG:      if (period_cnt == TRIG_LAST) state_next = WAIT_RISE;
      WAIT_RISE: begin
        if (echo_rise) begin
          state_next = MEASURE;
        end else if (to_expired) begin
          finish_timeout = 1'b1;
          state_next     = HOLDOFF;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          finish_ok  = 1'b1;
          state_next = HOLDOFF;
        end else if (to_expired) begin
          finish_timeout = 1'b1;
          state_next     = HOLDOFF;
        end
      end
      HOLDOFF:   if (period_cnt == PERIOD_LAST) state_next = i_en ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      period_cnt <= '0;
      to_cnt     <= '0;
      pre_cnt    <= '0;
      cm_cnt     <= '0;
      o_trig     <= 1'b0;
      o_range    <= '0;
      o_valid    <= 1'b0;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_trig    <= (state_next == TRIG);
      o_busy    <= (state_next != IDLE);
      o_valid   <= finish_ok | finish_timeout;
      o_timeout <= finish_timeout;
      if (finish_ok)           o_range <= cm_next;
      else if (finish_timeout) o_range <= RANGE_TOP;

      // period_cnt spans trigger entry to trigger entry; it also times the trigger pulse.
      if (state_next == TRIG && state != TRIG) period_cnt <= '0;
      else if (state != IDLE && period_cnt != PERIOD_LAST) period_cnt <= period_cnt + 1'b1;

      if (state == TRIG && state_next == WAIT_RISE) to_cnt <= '0;
      else if ((state == WAIT_RISE || state == MEASURE) && !to_expired) to_cnt <= to_cnt + 1'b1;

      if (state == WAIT_RISE && echo_rise) begin
        pre_cnt <= '0;
        cm_cnt  <= '0;
      end else if (state == MEASURE) begin
        pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
        cm_cnt  <= cm_next;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_range_meas.sv
// Randomised self-checking bench; scaled-down timing (1 cycle per us) keeps runs short.
module tb_ultrasonic_range_meas;

  localparam int CLK_HZ      = 1_000_000;
  localparam int TRIG_US     = 10;
  localparam int PERIOD_MS   = 2;
  localparam int TIMEOUT_US  = 1500;
  localparam int US_PER_CM   = 10;
  localparam int RANGE_W     = 7;
  localparam int CYC_PER_US  = CLK_HZ / 1_000_000;
  localparam int TRIG_CYC    = TRIG_US * CYC_PER_US;
  localparam int PERIOD_CYC  = PERIOD_MS * 1000 * CYC_PER_US;
  localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_PER_US;
  localparam int CM_CYC      = US_PER_CM * CYC_PER_US;
  localparam int RANGE_MAX   = (1 << RANGE_W) - 1;

  logic clk;
  logic rst;
  logic en;
  logic echo;
  logic trig;
  logic valid;
  logic timeout;
  logic busy;
  logic [RANGE_W-1:0] range;

  int check_count;
  int pass_count;
  int cyc;
  int last_rise;

  ultrasonic_range_meas #(
    .CLK_HZ    (CLK_HZ),
    .TRIG_US   (TRIG_US),
    .PERIOD_MS (PERIOD_MS),
    .TIMEOUT_US(TIMEOUT_US),
    .US_PER_CM (US_PER_CM),
    .RANGE_W   (RANGE_W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_echo   (echo),
    .o_trig   (trig),
    .o_range  (range),
    .o_valid  (valid),
    .o_timeout(timeout),
    .o_busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input int got, input int want);
    check_count++;
    if (got == want) pass_count++;
    else $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  task automatic waitTrigRise(input bit check_period);
    int prev;
    int budget;
    prev   = last_rise;
    budget = 0;
    while (!trig && budget < PERIOD_CYC + 20) begin
      tick();
      budget++;
    end
    checkOutput("trig_rise_seen", int'(trig), 1);
    last_rise = cyc;
    if (check_period) checkOutput("trig_period", last_rise - prev, PERIOD_CYC);
  endtask

  // Runs one measurement from the cycle the trigger rose. Echo is high from d to d+n-1
  // cycles after trigger fall; the model predicts the result from pulse timing alone.
  task automatic applyStimulus(input int d, input int n, input bit stuck,
                               input bit glitch, input bit drop_en);
    int width;
    int f;
    int valid_cnt;
    int got_tick;
    int got_range;
    int got_to;
    int exp_tick;
    int exp_range;
    bit exp_to;
    width     = 0;
    valid_cnt = 0;
    got_tick  = -1;
    got_range = -1;
    got_to    = -1;
    echo      = stuck;
    while (trig && width <= TRIG_CYC + 5) begin
      width++;
      tick();
    end
    checkOutput("trig_width", width, TRIG_CYC);
    f = cyc;
    for (int k = 0; k <= TIMEOUT_CYC + 5; k++) begin
      echo = stuck || (k >= d && k < d + n);
      if (drop_en && k == d + n / 2) en = 1'b0;
      tick();
      if (valid) begin
        valid_cnt++;
        if (got_tick < 0) begin
          got_tick  = cyc - f;
          got_range = int'(range);
          got_to    = int'(timeout);
        end
      end
    end
    echo = 1'b0;

    // Falling edge at the pin is visible 3 cycles later unless the window closed first.
    exp_to    = stuck || (d + n + 3 > TIMEOUT_CYC);
    exp_tick  = exp_to ? TIMEOUT_CYC : d + n + 3;
    exp_range = exp_to ? RANGE_MAX : ((n / CM_CYC > RANGE_MAX) ? RANGE_MAX : n / CM_CYC);
    checkOutput("valid_count", valid_cnt, 1);
    checkOutput("valid_time", got_tick, exp_tick);
    checkOutput("range", got_range, exp_range);
    checkOutput("timeout_flag", got_to, int'(exp_to));
    checkOutput("busy_holdoff", int'(busy), 1);

    if (glitch) begin
      valid_cnt = 0;
      for (int j = 0; j < 100; j++) begin
        echo = (j >= 10 && j < 50);
        tick();
        if (valid) valid_cnt++;
      end
      echo = 1'b0;
      checkOutput("glitch_no_valid", valid_cnt, 0);
      checkOutput("glitch_range_held", int'(range), exp_range);
    end
  endtask

  initial begin
    int trig_seen;
    int budget;
    check_count = 0;
    pass_count  = 0;
    cyc         = 0;
    last_rise   = 0;
    rst  = 1'b1;
    en   = 1'b1;
    echo = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", int'({trig, valid, timeout, busy, range}), 0);
    rst = 1'b0;
    tick();
    checkOutput("trig_after_reset", int'(trig), 1);
    checkOutput("busy_after_reset", int'(busy), 1);
    last_rise = cyc;

    applyStimulus(0, 100 * CM_CYC, 1'b0, 1'b0, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(3, CM_CYC - 1, 1'b0, 1'b0, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(3, CM_CYC, 1'b0, 1'b1, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(TIMEOUT_CYC + 100, 1, 1'b0, 1'b0, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(0, 1, 1'b1, 1'b0, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(0, (RANGE_MAX + 2) * CM_CYC, 1'b0, 1'b0, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(2, TIMEOUT_CYC - 5, 1'b0, 1'b0, 1'b0);
    waitTrigRise(1'b1);
    applyStimulus(2, TIMEOUT_CYC - 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      waitTrigRise(1'b1);
      applyStimulus(int'($urandom_range(40, 0)), int'($urandom_range(1600, 1)),
                    1'b0, 1'b0, 1'b0);
    end

    // Reset while an echo is being timed.
    waitTrigRise(1'b1);
    budget = 0;
    while (trig && budget < TRIG_CYC + 5) begin
      tick();
      budget++;
    end
    echo = 1'b1;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    checkOutput("reset_mid_measure", int'({trig, valid, timeout, busy, range}), 0);
    rst  = 1'b0;
    echo = 1'b0;
    tick();
    checkOutput("trig_after_mid_reset", int'(trig), 1);
    last_rise = cyc;

    applyStimulus(4, 50 * CM_CYC, 1'b0, 1'b0, 1'b1);
    trig_seen = 0;
    for (int j = 0; j < PERIOD_CYC + 50; j++) begin
      tick();
      if (trig) trig_seen++;
    end
    checkOutput("no_trig_after_disable", trig_seen, 0);
    checkOutput("idle_after_disable", int'(busy), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/ultrasonic_range_meas.md
Name: ultrasonic_range_meas

Overview:
Upstream front end for the drift scoring device. Drives an HC-SR04-style ultrasonic sensor and times its echo pulse. Converts the echo width to whole centimetres and publishes a 10-bit range word. This word replaces the switch-supplied range that score_module and range_speed_module consume.

Parameters:
CLK_HZ, 50_000_000, system clock frequency
TRIG_US, 10, trigger pulse width in microseconds
PERIOD_MS, 60, minimum interval between trigger rising edges
TIMEOUT_US, 38000, maximum wait for echo rise, and maximum echo high time, each measured from trigger fall
US_PER_CM, 58, round-trip echo microseconds per centimetre
RANGE_W, 10, range output width

Ports:
i_clk  in  1  system clock (MAX10_CLK1_50 domain)
i_rst  in  1  synchronous, active-high reset
i_en  in  1  measurement enable; free-runs while high
i_echo  in  1  raw sensor echo, asynchronous to i_clk
o_trig  out  1  sensor trigger pulse
o_range  out  RANGE_W  last measured range in cm, held between updates
o_valid  out  1  one-cycle strobe when o_range updates
o_timeout  out  1  one-cycle strobe, coincident with o_valid, when the measurement timed out
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Derived constants (cycles):
  - TRIG_CYC = CLK_HZ/1e6*TRIG_US = 500
  - PERIOD_CYC = 3_000_000
  - TIMEOUT_CYC = 1_900_000
  - CM_CYC = 2900
- i_echo passes through a 2-FF synchroniser. Edges are detected on the synchronised signal against a one-cycle-delayed copy.
- Reset values: o_trig=0, o_range=0, o_valid=0, o_timeout=0, o_busy=0, state=IDLE, all counters 0.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
  - IDLE: if i_en=1, go to TRIG next cycle and clear period_cnt.
  - TRIG: o_trig=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE and clear to_cnt.
  - WAIT_RISE: on a synchronised rising edge, go to MEASURE and clear cm_cnt and pre_cnt. If to_cnt reaches TIMEOUT_CYC-1 first, enter timeout handling.
  - MEASURE: pre_cnt counts 0..CM_CYC-1. On wrap, cm_cnt += 1, saturating at 2^RANGE_W-1.
    - On a synchronised falling edge: o_range <= cm_cnt (truncation, no rounding), pulse o_valid, go to HOLDOFF.
    - If to_cnt (still running since trigger fall) reaches TIMEOUT_CYC-1 first, enter timeout handling.
  - Timeout handling: o_range <= 2^RANGE_W-1 (1023 = "no target"), pulse o_valid and o_timeout together, go to HOLDOFF.
  - HOLDOFF: wait until period_cnt (running since TRIG entry) reaches PERIOD_CYC-1. Then go to TRIG if i_en=1, else IDLE.
- Latency: o_valid is asserted 3 i_clk cycles after i_echo falls at the pin (2 synchroniser cycles + 1 register cycle).
- i_en is sampled only in IDLE and at HOLDOFF exit. Deasserting it mid-measurement completes the current cycle, including its o_valid.
- If echo is already high on entry to WAIT_RISE, no rising edge exists. The block waits; a stuck-high echo therefore ends in timeout.
- Echo pulses seen in TRIG or HOLDOFF are ignored.
- Simultaneous falling edge and timeout in the same cycle: the edge wins, so o_timeout=0 and o_range=cm_cnt.
- Reset mid-operation: return to the reset values immediately. The trigger drops in the same cycle that reset is sampled.
- Counter widths: period_cnt 22 b, to_cnt 21 b, pre_cnt 12 b, cm_cnt RANGE_W b. All are clog2 of their derived constant.

Decomposition:
- Package range_meas_pkg holds:
  - the state enum typedef;
  - functions or localparams deriving TRIG_CYC, PERIOD_CYC, TIMEOUT_CYC, CM_CYC from the parameters;
  - RANGE_MAX.
- One sub-module, echo_sync: 2-FF synchroniser plus rise/fall edge strobes, synchronous reset to 0.

Test Plan:
- Reset with i_en=1, then release → o_trig high exactly 500 cycles starting 1 cycle after IDLE exit; o_busy=1.
- Echo high 290_000 cycles → o_range=100, o_valid one cycle at 3 cycles after echo falls, o_timeout=0.
- Echo high 2899 cycles → o_range=0. Echo high 2900 cycles → o_range=1.
- No echo → o_valid and o_timeout pulse together at trigger-fall+1_900_000 cycles; o_range=1023.
- Continuous i_en with a 100 cm target → trigger rising edges exactly 3_000_000 cycles apart. Dropping i_en mid-MEASURE still yields o_valid, then the FSM goes to IDLE and no further o_trig occurs.
- Assert i_rst during MEASURE → next cycle all outputs are 0 and the FSM is in IDLE. Echo glitches during HOLDOFF do not change o_range.
